// File: rtl/fp_pkg.sv
// Shared types and default widths for the FP add/sub alignment stage.
package fp_pkg;

    localparam int EW_DEF = 5;
    localparam int MW_DEF = 11;
    localparam int GRS    = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } align_state_t;

endpackage

// File: rtl/sticky_shr1.sv
// One-bit logical right shift that ORs the two lowest bits into the sticky position.
module sticky_shr1 #(
    parameter int N = 14
) (
    input  logic [N-1:0] v_i,
    output logic [N-1:0] v_o
);

    assign v_o = {1'b0, v_i[N-1:2], v_i[1] | v_i[0]};

endmodule

// File: rtl/fp_align_shift.sv
// Mantissa alignment stage: right-shifts the smaller-exponent mantissa one bit per cycle
// with guard/round/sticky kept, then presents the aligned pair over valid/ready.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// SHIFT | shifting the small mantissa, cnt counts remaining shifts
// DONE  | result presented, held until out_ready
module fp_align_shift
    import fp_pkg::*;
#(
    parameter int EW = EW_DEF,
    parameter int MW = MW_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [EW-1:0]   exp_a,
    input  logic [EW-1:0]   exp_b,
    input  logic [MW-1:0]   mant_a,
    input  logic [MW-1:0]   mant_b,
    input  logic [EW-1:0]   exp_diff,
    input  logic            a_ge_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [EW-1:0]   exp_out,
    output logic [MW+2:0]   mant_big,
    output logic [MW+2:0]   mant_small,
    output logic            swapped
);

    localparam int W = MW + GRS;
    localparam logic [EW-1:0] CNT_SAT = EW'(W);

    // The shift counter must be able to hold the full mantissa width.
    if (W > (2**EW) - 1) begin : g_width_check
        $error("fp_align_shift: MW+3 does not fit in an EW-bit shift counter");
    end

    align_state_t  state_q, state_d;
    logic [EW-1:0] cnt_q, cnt_d;
    logic [EW-1:0] exp_q, exp_d;
    logic [W-1:0]  big_q, big_d;
    logic [W-1:0]  small_q, small_d;
    logic          swapped_q, swapped_d;
    logic          out_valid_q, out_valid_d;

    logic          accept;
    logic          xfer;
    logic [EW-1:0] cnt_init;
    logic [W-1:0]  small_shr;

    sticky_shr1 #(.N(W)) u_shr (
        .v_i (small_q),
        .v_o (small_shr)
    );

    assign accept   = in_valid && in_ready;
    assign xfer     = out_valid_q && out_ready;
    // Differences beyond the mantissa width all collapse into sticky, so cap the count.
    assign cnt_init = (exp_diff >= CNT_SAT) ? CNT_SAT : exp_diff;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            exp_q       <= '0;
            big_q       <= '0;
            small_q     <= '0;
            swapped_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            exp_q       <= exp_d;
            big_q       <= big_d;
            small_q     <= small_d;
            swapped_q   <= swapped_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = (cnt_init == '0) ? DONE : SHIFT;
            SHIFT:   if (cnt_q == EW'(1)) state_d = DONE;
            DONE:    if (xfer) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d       = cnt_q;
        exp_d       = exp_q;
        big_d       = big_q;
        small_d     = small_q;
        swapped_d   = swapped_q;
        out_valid_d = (state_q == DONE) && !xfer;
        if (state_q == IDLE && accept) begin
            cnt_d     = cnt_init;
            swapped_d = !a_ge_b;
            if (a_ge_b) begin
                exp_d   = exp_a;
                big_d   = {mant_a, 3'b000};
                small_d = {mant_b, 3'b000};
            end else begin
                exp_d   = exp_b;
                big_d   = {mant_b, 3'b000};
                small_d = {mant_a, 3'b000};
            end
        end else if (state_q == SHIFT) begin
            cnt_d   = cnt_q - EW'(1);
            small_d = small_shr;
        end
    end

    always_comb begin
        in_ready = (state_q == IDLE) && !rst;
    end

    assign out_valid  = out_valid_q;
    assign exp_out    = exp_q;
    assign mant_big   = big_q;
    assign mant_small = small_q;
    assign swapped    = swapped_q;

endmodule

// File: tb/tb_fp_align_shift.sv
// Bench for fp_align_shift: directed vector table, hand-written corner sequences and
// randomized operations checked against an arithmetic alignment model.
module tb_fp_align_shift;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [4:0]  exp_a, exp_b, exp_diff;
    logic [10:0] mant_a, mant_b;
    logic        a_ge_b;
    logic        out_valid, out_ready;
    logic [4:0]  exp_out;
    logic [13:0] mant_big, mant_small;
    logic        swapped;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fp_align_shift dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .exp_a      (exp_a),
        .exp_b      (exp_b),
        .mant_a     (mant_a),
        .mant_b     (mant_b),
        .exp_diff   (exp_diff),
        .a_ge_b     (a_ge_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .exp_out    (exp_out),
        .mant_big   (mant_big),
        .mant_small (mant_small),
        .swapped    (swapped)
    );

    typedef struct {
        logic [4:0]  ea, eb, df;
        logic [10:0] ma, mb;
        logic        ag;
        logic [13:0] xb, xs;
        logic [4:0]  xe;
        logic        xsw;
        int          xlat;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Alignment as arithmetic: divide by 2^k, then OR every bit shifted out into bit 0.
    function automatic logic [13:0] align_ref(input logic [10:0] m, input int n);
        int v, k, r;
        v = int'(m) * 8;
        k = (n > 14) ? 14 : n;
        r = (v >> k) & ~1;
        if ((v % (1 << (k + 1))) != 0) r = r | 1;
        return r[13:0];
    endfunction

    task automatic run_op(input string nm,
                          input logic [4:0] ea, input logic [4:0] eb,
                          input logic [10:0] ma, input logic [10:0] mb,
                          input logic [4:0] df, input logic ag,
                          input logic [13:0] xb, input logic [13:0] xs,
                          input logic [4:0] xe, input logic xsw,
                          input int xlat, input int dly);
        int waitc;
        int lat;
        @(negedge clk);
        exp_a = ea; exp_b = eb; mant_a = ma; mant_b = mb;
        exp_diff = df; a_ge_b = ag; in_valid = 1'b1; out_ready = 1'b0;
        waitc = 0;
        while (!in_ready && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        chk({nm, " in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        exp_a = 5'($urandom); exp_b = 5'($urandom);
        mant_a = 11'($urandom); mant_b = 11'($urandom);
        exp_diff = 5'($urandom); a_ge_b = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk({nm, " latency"}, 32'(lat), 32'(xlat));
        chk({nm, " mant_big"}, 32'(mant_big), 32'(xb));
        chk({nm, " mant_small"}, 32'(mant_small), 32'(xs));
        chk({nm, " exp_out"}, 32'(exp_out), 32'(xe));
        chk({nm, " swapped"}, 32'(swapped), 32'(xsw));
        chk({nm, " in_ready_done"}, 32'(in_ready), 32'd0);
        for (int i = 0; i < dly; i++) begin
            @(negedge clk);
            chk({nm, " hold_valid"}, 32'(out_valid), 32'd1);
            chk({nm, " hold_small"}, 32'(mant_small), 32'(xs));
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({nm, " valid_drop"}, 32'(out_valid), 32'd0);
        chk({nm, " ready_back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int lat;
        tbl[0] = '{ea:15, eb:13, df:2,  ma:11'h400, mb:11'h600, ag:1, xb:14'h2000, xs:14'h0C00, xe:15, xsw:0, xlat:3};
        tbl[1] = '{ea:3,  eb:7,  df:4,  ma:11'h401, mb:11'h7FF, ag:0, xb:14'h3FF8, xs:14'h0201, xe:7,  xsw:1, xlat:5};
        tbl[2] = '{ea:10, eb:10, df:0,  ma:11'h500, mb:11'h480, ag:1, xb:14'h2800, xs:14'h2400, xe:10, xsw:0, xlat:1};
        tbl[3] = '{ea:25, eb:5,  df:20, ma:11'h555, mb:11'h401, ag:1, xb:14'h2AA8, xs:14'h0001, xe:25, xsw:0, xlat:15};
        tbl[4] = '{ea:25, eb:5,  df:20, ma:11'h555, mb:11'h000, ag:1, xb:14'h2AA8, xs:14'h0000, xe:25, xsw:0, xlat:15};
        tbl[5] = '{ea:20, eb:7,  df:13, ma:11'h400, mb:11'h7FF, ag:1, xb:14'h2000, xs:14'h0001, xe:20, xsw:0, xlat:14};
        tbl[6] = '{ea:21, eb:7,  df:14, ma:11'h400, mb:11'h400, ag:1, xb:14'h2000, xs:14'h0001, xe:21, xsw:0, xlat:15};
        tbl[7] = '{ea:8,  eb:9,  df:1,  ma:11'h001, mb:11'h123, ag:0, xb:14'h0918, xs:14'h0004, xe:9,  xsw:1, xlat:2};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        exp_a = '0; exp_b = '0; mant_a = '0; mant_b = '0; exp_diff = '0; a_ge_b = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst in_ready", 32'(in_ready), 32'd0);
        chk("rst outputs", 32'({exp_out, mant_big, mant_small, swapped}), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++)
            run_op($sformatf("vec%0d", i), tbl[i].ea, tbl[i].eb, tbl[i].ma, tbl[i].mb,
                   tbl[i].df, tbl[i].ag, tbl[i].xb, tbl[i].xs, tbl[i].xe, tbl[i].xsw,
                   tbl[i].xlat, i % 3);

        // Backpressure with a second request pending during SHIFT/DONE.
        @(negedge clk);
        exp_a = 15; exp_b = 13; mant_a = 11'h400; mant_b = 11'h600;
        exp_diff = 2; a_ge_b = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        exp_a = 9; exp_b = 9; mant_a = 11'h123; mant_b = 11'h456; exp_diff = 0; a_ge_b = 1'b1;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("bp latency", 32'(lat), 32'd3);
        for (int i = 0; i < 5; i++) begin
            chk("bp valid", 32'(out_valid), 32'd1);
            chk("bp big", 32'(mant_big), 32'h2000);
            chk("bp small", 32'(mant_small), 32'h0C00);
            chk("bp in_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp drop", 32'(out_valid), 32'd0);
        chk("bp ready_after", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp second accepted", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("bp second valid", 32'(out_valid), 32'd1);
        chk("bp second big", 32'(mant_big), 32'h0918);
        chk("bp second small", 32'(mant_small), 32'h22B0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Reset in the middle of a long shift.
        @(negedge clk);
        exp_a = 20; exp_b = 10; mant_a = 11'h7FF; mant_b = 11'h3FF;
        exp_diff = 10; a_ge_b = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid rst out_valid", 32'(out_valid), 32'd0);
        chk("mid rst outputs", 32'({exp_out, mant_big, mant_small, swapped}), 32'd0);
        chk("mid rst in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post rst in_ready", 32'(in_ready), 32'd1);
        chk("post rst out_valid", 32'(out_valid), 32'd0);

        for (int i = 0; i < 150; i++) begin
            logic [4:0]  ea, eb, df;
            logic [10:0] ma, mb;
            logic        ag;
            int          d;
            ea = 5'($urandom); eb = 5'($urandom);
            ma = 11'($urandom); mb = 11'($urandom);
            if (i % 10 == 0) mb = '0;
            if (i % 7 == 0) eb = ea;
            ag = (ea >= eb);
            d  = ag ? int'(ea) - int'(eb) : int'(eb) - int'(ea);
            df = 5'(d);
            run_op($sformatf("rnd%0d", i), ea, eb, ma, mb, df, ag,
                   ag ? {ma, 3'b000} : {mb, 3'b000},
                   align_ref(ag ? mb : ma, d),
                   ag ? ea : eb, !ag, ((d > 14) ? 14 : d) + 1,
                   int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, %0d comparisons made", n_cmp);
        $fatal(1, "timeout");
    end

endmodule
